script_fetch: RTL and testbench
===============================

Name: script_fetch

Overview:
- Upstream fetch stage of the script engine. Holds the script program counter and reads the byte-wide script RAM, two bytes per instruction.
- Assembles each 16-bit instruction word (i_num[15:8], i_sign[7:5], fun[4:3], op_code[2:0]) and offers it with its PC to the downstream script decoder over a valid/ready handshake.
- Applies jump targets and halt requests returned by the decoder.

Parameters:
- ADDR_W, 8, script RAM address / PC width.
- START_PC, 0, PC loaded on start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin script execution at START_PC
- stop  in  1  abort: return to IDLE
- mem_addr  out  ADDR_W  script RAM read address
- mem_rd  out  1  script RAM read enable
- mem_data  in  8  script RAM read data, valid one cycle after mem_rd
- instr  out  16  assembled instruction
- instr_pc  out  ADDR_W  address of instr's low byte
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decoder accepts instr
- jump_valid  in  1  decoder requests jump; sampled only at handshake
- jump_target  in  ADDR_W  jump destination
- halt  in  1  decoder signals end of script; sampled only at handshake
- busy  out  1  high in any state except IDLE/HALTED
- done  out  1  one-cycle pulse on entering HALTED
- align_err  out  1  sticky: odd jump target seen; cleared by start

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, pc=START_PC
  - instr=0, instr_pc=0, instr_valid=0, busy=0, done=0, align_err=0
- Byte order: mem[pc] gives instr[7:0]; mem[pc+1] gives instr[15:8].
- States:
  - IDLE/HALTED: mem_rd=0. On start, load pc=START_PC, clear align_err, go to RD_LO.
  - RD_LO: mem_addr=pc, mem_rd=1. Next state RD_HI.
  - RD_HI: mem_addr=pc+1, mem_rd=1. Latch mem_data into instr[7:0]. Next state RD_WAIT.
  - RD_WAIT: mem_rd=0. Latch mem_data into instr[15:8], instr_pc<=pc, instr_valid<=1. Next state PRESENT.
  - PRESENT: hold instr, instr_pc and instr_valid stable until instr_ready=1. Then drop instr_valid on the next edge and act on the first matching case:
    - halt=1: go to HALTED; pulse done.
    - jump_valid=1: pc<=jump_target with bit0 forced to 0; set align_err if jump_target[0]=1; go to RD_LO.
    - otherwise: pc<=pc+2 (mod 2^ADDR_W); go to RD_LO.
- Latency: start at edge N gives instr_valid=1 after edge N+3. Back-to-back throughput is one instruction per 4 cycles with instr_ready tied high.
- Output timing: mem_addr and mem_rd are combinational from state and pc. All other outputs are registered.
- PC wrap: pc=8'hFE plus 2 becomes 8'h00 with no flag. Reading pc+1 at 8'hFF wraps to 8'h00.
- Priority rules:
  - halt and jump_valid together at handshake: halt wins.
  - stop has highest priority in every state. Next edge: IDLE, instr_valid=0, busy=0, no done pulse.
  - stop and start in the same cycle: stop wins.
  - start while busy: ignored.
  - jump_valid/halt outside a handshake cycle: ignored.
- Reset mid-fetch: all registers return to reset values immediately. The partially assembled instruction is discarded.
- busy=1 in RD_LO, RD_HI, RD_WAIT and PRESENT.

Decomposition:
- Shared package script_pkg:
  - ADDR_W and START_PC defaults
  - fetch state encoding (IDLE, RD_LO, RD_HI, RD_WAIT, PRESENT, HALTED)
  - instruction field slice constants (I_NUM 15:8, I_SIGN 7:5, FUN 4:3, OP_CODE 2:0), shared with the decoder
- No sub-module: one FSM plus datapath registers. The bench supplies a behavioural script RAM model (script_rom_model) with one-cycle read latency.

Test Plan:
- Linear fetch: RAM[0..3]=8'h21,8'h05,8'h09,8'h10, instr_ready=1, start pulse -> instr=16'h0521 at instr_pc=0 valid 3 cycles after start, then instr=16'h1009 at instr_pc=2 exactly 4 cycles later.
- Backpressure: hold instr_ready=0 for 10 cycles in PRESENT -> instr, instr_pc and instr_valid stable, mem_rd=0 throughout; release -> next fetch at pc+2.
- Jump: at handshake for instr_pc=4 assert jump_valid, jump_target=8'h11 -> next mem_addr=8'h10, next instr_pc=8'h10, align_err=1; new start clears align_err.
- Wrap: jump to 8'hFE, RAM[FE]=8'hAA, RAM[FF]=8'hBB -> instr=16'hBBAA, instr_pc=8'hFE; following mem_addr=8'h00.
- Halt priority: handshake with halt=1 and jump_valid=1 -> HALTED, done pulses once, busy=0, no further mem_rd.
- Abort/reset: stop asserted in RD_HI -> IDLE next edge, instr_valid never rises. Separately, rst_n=0 in PRESENT -> instr_valid=0 and pc=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/script_pkg.sv
// Shared script-engine definitions: fetch state encoding,
// default geometry and instruction field positions.
package script_pkg;

   localparam int SCRIPT_ADDR_W   = 8;
   localparam int SCRIPT_START_PC = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_RD_WAIT,
      S_PRESENT,
      S_HALTED
   } fetch_state_e;

   localparam int I_NUM_HI   = 15;
   localparam int I_NUM_LO   = 8;
   localparam int I_SIGN_HI  = 7;
   localparam int I_SIGN_LO  = 5;
   localparam int FUN_HI     = 4;
   localparam int FUN_LO     = 3;
   localparam int OP_CODE_HI = 2;
   localparam int OP_CODE_LO = 0;

endpackage

// File: rtl/script_fetch.sv
// Script fetch stage: reads two RAM bytes per instruction and
// presents the word to the decoder over valid/ready.
module script_fetch
   import script_pkg::*;
#(
   parameter int ADDR_W   = SCRIPT_ADDR_W,
   parameter int START_PC = SCRIPT_START_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              halt,
   output logic              busy,
   output logic              done,
   output logic              align_err
);

   localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(START_PC);

   fetch_state_e      state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic              set_align, clr_align;

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      set_align = 1'b0;
      clr_align = 1'b0;
      mem_addr  = pc;
      mem_rd    = 1'b0;
      unique case (state)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_nx     = PC0;
               clr_align = 1'b1;
               state_nx  = S_RD_LO;
            end
         end
         S_RD_LO: begin
            mem_rd   = 1'b1;
            state_nx = S_RD_HI;
         end
         S_RD_HI: begin
            mem_addr = pc + ADDR_W'(1);
            mem_rd   = 1'b1;
            state_nx = S_RD_WAIT;
         end
         S_RD_WAIT: state_nx = S_PRESENT;
         S_PRESENT: begin
            if (instr_ready) begin
               if (halt) begin
                  state_nx = S_HALTED;
               end else if (jump_valid) begin
                  pc_nx     = {jump_target[ADDR_W-1:1], 1'b0};
                  set_align = jump_target[0];
                  state_nx  = S_RD_LO;
               end else begin
                  pc_nx    = pc + ADDR_W'(2);
                  state_nx = S_RD_LO;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // Abort overrides any transition, including a same-cycle start.
      if (stop) begin
         state_nx  = S_IDLE;
         pc_nx     = pc;
         set_align = 1'b0;
         clr_align = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= PC0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         align_err   <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         instr_valid <= (state_nx == S_PRESENT);
         busy        <= (state_nx != S_IDLE) && (state_nx != S_HALTED);
         done        <= (state_nx == S_HALTED) && (state != S_HALTED);
         if (set_align)
            align_err <= 1'b1;
         else if (clr_align)
            align_err <= 1'b0;
         if (state == S_RD_HI)
            instr[I_SIGN_HI:OP_CODE_LO] <= mem_data;
         if (state == S_RD_WAIT) begin
            instr[I_NUM_HI:I_NUM_LO] <= mem_data;
            instr_pc                 <= pc;
         end
      end
   end

endmodule

// File: tb/tb_script_fetch.sv
// Bench for script_fetch: byte RAM model with one-cycle latency
// and a scoreboard of expected instructions consumed at handshake.
module tb_script_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid, instr_ready;
   logic        jump_valid;
   logic [7:0]  jump_target;
   logic        halt;
   logic        busy, done, align_err;

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  pc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] rom [256];
   int         n_chk  = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   script_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .halt        (halt),
      .busy        (busy),
      .done        (done),
      .align_err   (align_err)
   );

   // script_rom_model
   always @(posedge clk)
      if (mem_rd) mem_data <= rom[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic exp_t mk(input logic [7:0] a);
      exp_t e;
      logic [7:0] b;
      b = a + 8'd1;
      e.instr = {rom[b], rom[a]};
      e.pc    = a;
      return e;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (!instr_valid) chk(tag, 0, 1);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst_n && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            chk("sb_extra", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_instr", instr, e.instr);
            chk("sb_pc", instr_pc, e.pc);
         end
      end
   end

   initial begin
      foreach (rom[i]) rom[i] = 8'h00;
      rom[8'h00] = 8'h21; rom[8'h01] = 8'h05;
      rom[8'h02] = 8'h09; rom[8'h03] = 8'h10;
      rom[8'h04] = 8'h33; rom[8'h05] = 8'h44;
      rom[8'h10] = 8'h77; rom[8'h11] = 8'h88;
      rom[8'hFE] = 8'hAA; rom[8'hFF] = 8'hBB;
      rst_n = 1'b0; start = 0; stop = 0; instr_ready = 0;
      jump_valid = 0; jump_target = 0; halt = 0;
      cyc(); cyc();
      chk("rst_valid", instr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_align", align_err, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_mem_rd", mem_rd, 0);
      rst_n = 1'b1;
      cyc();

      // linear fetch and latency
      instr_ready = 1;
      sb.push_back(mk(8'h00));
      sb.push_back(mk(8'h02));
      start = 1; cyc(); start = 0;
      chk("lat_busy", busy, 1);
      chk("lat_v0", instr_valid, 0);
      cyc(); chk("lat_v1", instr_valid, 0);
      cyc(); chk("lat_v2", instr_valid, 0);
      cyc(); chk("lat_v3", instr_valid, 1);
      chk("lat_instr", instr, 16'h0521);
      chk("lat_pc", instr_pc, 0);
      cyc();
      instr_ready = 0;
      chk("thr_addr", mem_addr, 8'h02);
      chk("thr_rd", mem_rd, 1);
      chk("thr_v0", instr_valid, 0);
      cyc(); chk("thr_v1", instr_valid, 0);
      cyc(); chk("thr_v2", instr_valid, 0);
      cyc(); chk("thr_v3", instr_valid, 1);
      chk("thr_instr", instr, 16'h1009);
      chk("thr_pc", instr_pc, 8'h02);

      // backpressure
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_valid", instr_valid, 1);
         chk("bp_instr", instr, 16'h1009);
         chk("bp_pc", instr_pc, 8'h02);
         chk("bp_rd", mem_rd, 0);
      end
      sb.push_back(mk(8'h04));
      instr_ready = 1;
      cyc();
      chk("bp_next", mem_addr, 8'h04);
      chk("bp_next_rd", mem_rd, 1);

      // jump with odd target
      wait_valid("jmp_wait");
      chk("jmp_src_pc", instr_pc, 8'h04);
      sb.push_back(mk(8'h10));
      jump_valid = 1; jump_target = 8'h11;
      cyc();
      jump_valid = 0; jump_target = 0;
      chk("jmp_addr", mem_addr, 8'h10);
      chk("jmp_align", align_err, 1);
      wait_valid("jmp_wait2");
      chk("jmp_pc", instr_pc, 8'h10);

      // wrap
      sb.push_back(mk(8'hFE));
      jump_valid = 1; jump_target = 8'hFE;
      cyc();
      jump_valid = 0; jump_target = 0;
      chk("wrap_lo", mem_addr, 8'hFE);
      cyc();
      chk("wrap_hi", mem_addr, 8'hFF);
      wait_valid("wrap_wait");
      chk("wrap_instr", instr, 16'hBBAA);
      chk("wrap_sticky", align_err, 1);
      sb.push_back(mk(8'h00));
      cyc();
      chk("wrap_addr", mem_addr, 8'h00);
      chk("wrap_rd", mem_rd, 1);

      // halt beats jump
      wait_valid("halt_wait");
      halt = 1; jump_valid = 1; jump_target = 8'h20;
      cyc();
      halt = 0; jump_valid = 0; jump_target = 0;
      chk("halt_done", done, 1);
      chk("halt_busy", busy, 0);
      chk("halt_valid", instr_valid, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("halt_done_once", done, 0);
         chk("halt_no_rd", mem_rd, 0);
      end

      // restart clears align, then abort in RD_HI
      start = 1; cyc(); start = 0;
      chk("st_align", align_err, 0);
      chk("st_busy", busy, 1);
      cyc();
      chk("ab_in_hi", mem_addr, 8'h01);
      stop = 1; cyc(); stop = 0;
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("ab_valid", instr_valid, 0);
         chk("ab_rd", mem_rd, 0);
      end
      stop = 1; start = 1; cyc(); stop = 0; start = 0;
      chk("stop_start", busy, 0);

      // async reset while presenting
      instr_ready = 0;
      sb.push_back(mk(8'h00));
      start = 1; cyc(); start = 0;
      wait_valid("rs_wait0");
      instr_ready = 1; cyc(); instr_ready = 0;
      wait_valid("rs_wait1");
      chk("rs_pre_pc", instr_pc, 8'h02);
      chk("rs_pre_addr", mem_addr, 8'h02);
      #3 rst_n = 1'b0;
      #1;
      chk("rs_valid", instr_valid, 0);
      chk("rs_addr", mem_addr, 8'h00);
      chk("rs_busy", busy, 0);
      chk("rs_instr", instr, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("sb_drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
